bidirec_port: RTL and testbench

- Registered bidirectional data-pad interface.
- Drives a shared tri-state bus from a registered copy of `inp` while output-enable is asserted.
- Releases the bus to high-Z otherwise.
- Continuously samples the bus into a capture register presented on `outp`.
- Sits between core logic and a shared pad/bus; all paths are registered for clean pad timing.

---
 rtl/bidirec_port.sv | 52 +++++
 tb/tb_bidirec_port.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bidirec_port.sv
`timescale 1ns/1ps
// bidirec_port: registered bidirectional pad interface.
// The block drives the shared bus from a registered copy of inp while the
// registered enable is high. Otherwise it releases the bus to high-Z.
// The resolved bus value is sampled into a capture register on every edge,
// and that register drives outp. No path from an input port to an output
// port or to the pad is combinational.
module bidirec_port #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             oe,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] outp,
  inout  wire  [WIDTH-1:0] bidir
);

  // Data and enable are registered on the same edge. This keeps the bus from
  // ever showing data from a different cycle than the enable that gates it.
  logic [WIDTH-1:0] drive_q, drive_d;
  logic             oe_q,    oe_d;
  logic [WIDTH-1:0] cap_q,   cap_d;

  // Next-state values: take data and enable as presented, and capture the
  // resolved bus. While the block drives the bus, the capture is its own
  // value fed back (loopback).
  always_comb begin
    drive_d = inp;
    oe_d    = oe;
    cap_d   = bidir;
  end

  // All state clears immediately on reset. The pad therefore floats and outp
  // reads zero without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drive_q <= '0;
      oe_q    <= 1'b0;
      cap_q   <= '0;
    end else begin
      drive_q <= drive_d;
      oe_q    <= oe_d;
      cap_q   <= cap_d;
    end
  end

  // The pad is driven only from registers.
  assign bidir = oe_q ? drive_q : {WIDTH{1'bz}};
  assign outp  = cap_q;

endmodule

// File: tb/tb_bidirec_port.sv
`timescale 1ns/1ps
module tb_bidirec_port;
  localparam int W = 8;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         oe      = 1'b0;
  logic [W-1:0] inp     = '0;
  logic [W-1:0] outp;
  wire  [W-1:0] bidir;

  // External agent on the shared bus. It drives only while the block is expected to be released.
  logic         ext_en  = 1'b0;
  logic [W-1:0] ext_val = '0;
  assign bidir = ext_en ? ext_val : {W{1'bz}};

  int checks   = 0;
  int failures = 0;

  // Reference model: what the pad was told at the most recent edge.
  //   told_drive : the block owns the bus during the current cycle
  //   told_data  : data it puts on the bus if it owns it
  //   last_seen  : bus value seen at the most recent edge; this is what outp shows
  logic         told_drive = 1'b0;
  logic [W-1:0] told_data  = '0;
  logic [W-1:0] last_seen  = '0;

  bidirec_port #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .oe    (oe),
    .inp   (inp),
    .outp  (outp),
    .bidir (bidir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected bus content for the current cycle.
  function automatic logic [W-1:0] bus_expect();
    return told_drive ? told_data : ext_val;
  endfunction

  // Reset empties the pad's memory: it floats, and nothing has been seen.
  task automatic model_reset();
    told_drive = 1'b0;
    told_data  = '0;
    last_seen  = '0;
  endtask

  // One clock step, entered and left just after a falling edge.
  // Present oe/data. At the rising edge, the bus value of the ending cycle is
  // what gets captured. After the edge, the agent takes the bus if the pad
  // released it. Then both outputs are checked.
  task automatic step(input logic o, input logic [W-1:0] d, input logic [W-1:0] ext_v, input string tag);
    logic [W-1:0] bus_at_edge;
    oe  = o;
    inp = d;
    @(posedge clk);
    bus_at_edge = bus_expect();
    told_drive  = o;
    told_data   = d;
    last_seen   = bus_at_edge;
    @(negedge clk);
    ext_en  = !told_drive;
    ext_val = ext_v;
    #1;
    check({tag, "_bus"},  bidir, bus_expect());
    check({tag, "_outp"}, outp,  last_seen);
  endtask

  initial begin
    // Reset held with a drive request pending. The agent holds the bus, so a
    // block that drives here would collide with it.
    rst_n   = 1'b0;
    oe      = 1'b1;
    inp     = 8'hA5;
    ext_en  = 1'b1;
    ext_val = 8'h3C;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("reset_bus",  bidir, 8'h3C);
    check("reset_outp", outp,  8'h00);

    // Release reset. The first edge drives A5; outp shows A5 one edge later.
    rst_n = 1'b1;
    step(1'b1, 8'hA5, 8'h00, "rst_first");
    check("rst_first_drv", bidir, 8'hA5);
    step(1'b1, 8'hA5, 8'h00, "rst_loop");
    check("rst_loop_outp", outp, 8'hA5);

    // Drive sequence 0..4. The bus lags by 1 cycle and outp by 2 cycles.
    for (int i = 0; i < 5; i++) step(1'b1, W'(i), 8'h00, "drive_seq");
    step(1'b1, 8'h04, 8'h00, "drive_hold");
    step(1'b1, 8'h04, 8'h00, "drive_hold");

    // Release and capture. The data is chosen so that a pad that keeps driving would corrupt 3C.
    step(1'b0, 8'hC3, 8'h3C, "release");
    step(1'b0, 8'hC3, 8'h3C, "capture");
    check("capture_val", outp, 8'h3C);

    // Enable toggles every cycle while the data steps 0..4. The agent drives FF when the pad is released.
    for (int i = 0; i < 10; i++) step((i % 2) == 0, W'(i / 2), 8'hFF, "toggle");

    // Data loaded while the pad is released shows on the first drive cycle.
    repeat (3) step(1'b0, 8'h77, 8'h08, "preload_idle");
    step(1'b1, 8'h77, 8'h08, "preload_drive");
    check("preload_first", bidir, 8'h77);

    // Random traffic.
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), "random");

    // Asynchronous reset while the pad drives 55. The agent takes the bus with
    // AA in the same instant. The bus must show AA and outp must read 0 before any clock edge.
    step(1'b1, 8'h55, 8'h00, "pre_async");
    step(1'b1, 8'h55, 8'h00, "pre_async");
    #2;
    rst_n   = 1'b0;
    ext_en  = 1'b1;
    ext_val = 8'hAA;
    model_reset();
    #1;
    check("async_bus",  bidir, 8'hAA);
    check("async_outp", outp,  8'h00);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("async_hold_bus",  bidir, 8'hAA);
    check("async_hold_outp", outp,  8'h00);
    rst_n = 1'b1;
    step(1'b0, 8'h12, 8'hAA, "post_async");
    step(1'b1, 8'h12, 8'hAA, "post_async");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
